niossoc_pio_out_pulse: RTL and testbench
========================================

Name: niossoc_pio_out_pulse

Overview:
Avalon-MM slave output PIO for the NIOSsoc system. It is the write-direction counterpart of the system's read-only input PIOs. The NIOS CPU writes a 32-bit output register that drives `out_port` directly to fabric or board logic. The register supports atomic bit-set and bit-clear, and a hardware-timed auto-clearing pulse so that software does not have to busy-wait to generate strobes.

Parameters:
DATA_WIDTH, 32, width of `out_port`, the data register and the write/read data buses.
RESET_VALUE, 0, value loaded into the data register on reset.
PULSE_CNT_WIDTH, 16, width of the PULSE_LEN register and the pulse down-counter.

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
address  input  3  Avalon word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
writedata  input  DATA_WIDTH  write data
readdata  output  DATA_WIDTH  registered read data
out_port  output  DATA_WIDTH  driven output (equals the data register)

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - data register = RESET_VALUE
  - PULSE_LEN = 0, pulse_mask = 0, counter = 0, busy = 0
  - readdata = 0
  - Reset mid-pulse aborts the pulse; bits take RESET_VALUE.
- Register map (word addresses):
  - 0 DATA: R/W. Write: data <= writedata.
  - 1 PULSE_LEN: R/W, low PULSE_CNT_WIDTH bits. Upper read bits are 0.
  - 2 STATUS: read-only. bit0 = busy, other bits 0. Writes ignored.
  - 3 PULSE: write-only, reads 0.
  - 4 OUTSET: write-only, reads 0. data <= data | writedata.
  - 5 OUTCLEAR: write-only, reads 0. data <= data & ~writedata.
  - 6, 7: read 0, writes ignored.
- Read path:
  - readdata <= mux(address) every cycle, not gated by chipselect.
  - Read latency is 1 cycle; no wait states.
- Write path: zero wait states; the effect is visible on `out_port` the cycle after the write edge.
- PULSE write, with PULSE_LEN != 0:
  - data <= data | writedata
  - pulse_mask <= writedata
  - counter <= PULSE_LEN
  - busy <= 1
- PULSE write with PULSE_LEN = 0 is ignored; no state changes.
- Pulse countdown while busy:
  - Counter decrements each cycle.
  - On the edge where counter == 1: data <= data & ~pulse_mask, busy <= 0, pulse_mask <= 0.
  - Net effect: the pulsed bits are high for exactly PULSE_LEN cycles.
- Retrigger while busy, with a PULSE write that is not on the expiry edge:
  - pulse_mask <= pulse_mask | writedata
  - counter reloads to PULSE_LEN
- Expiry on the same edge as a PULSE write:
  - Old mask bits are cleared first, then the new bits are set.
  - pulse_mask <= writedata; counter reloads; busy stays 1.
- Expiry on the same edge as a DATA/OUTSET/OUTCLEAR write:
  - The expiry clear is applied first, then the write. The write wins on overlapping bits.
- DATA/OUTSET/OUTCLEAR writes during a pulse change `data` immediately but do not alter the counter or pulse_mask. Expiry still clears pulse_mask bits.
- A PULSE_LEN write during a pulse affects only the next load, not the running counter.
- Counter arithmetic is unsigned. The maximum pulse is 2^PULSE_CNT_WIDTH-1 cycles. There is no wrap, because the counter is only decremented while busy and counter >= 1.

Optional Feature:
Macro OUTPIO_PULSE_EN.
- Defined: the PULSE_LEN, PULSE and STATUS registers and the counter logic exist as described above.
- Undefined:
  - Addresses 1, 2 and 3 read 0 and ignore writes.
  - No counter or pulse_mask flops are present.
  - `out_port` changes only via DATA, OUTSET and OUTCLEAR.

Test Plan:
1. Reset with RESET_VALUE=0xA5 -> out_port=0x000000A5, readdata=0. Read addr 0 -> readdata=0x000000A5 one cycle after address is presented.
2. Write DATA=0x0000FF00, then OUTSET 0x0000000F, then OUTCLEAR 0x00000F00 -> out_port goes 0x0000FF00 -> 0x0000FF0F -> 0x0000F00F on consecutive cycles. Read addr 4 -> 0.
3. PULSE_LEN=3, DATA=0, PULSE 0x1 -> out_port bit0 high for exactly 3 cycles; STATUS reads 1 during the pulse and 0 after; out_port returns to 0.
4. PULSE_LEN=4, PULSE 0x1, then PULSE 0x2 two cycles later -> bit0 high 6 cycles, bit1 high 4 cycles, both clear on the same edge.
5. PULSE_LEN=2, PULSE 0x3, with OUTSET 0x1 on the expiry edge -> after expiry out_port=0x1, busy=0. PULSE_LEN=0 then PULSE 0x8 -> out_port unchanged, busy=0.
6. Mid-pulse (PULSE_LEN=10, PULSE 0xF0, 3 cycles in) assert reset_n=0 for one edge -> out_port=RESET_VALUE, STATUS=0, and no later clear event occurs.

Source files
------------

// File: rtl/niossoc_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a hardware-timed auto-clearing pulse.
// The pulse engine (PULSE_LEN, STATUS, PULSE registers and the down-counter) exists only when OUTPIO_PULSE_EN is defined.
`timescale 1ns/1ps
module niossoc_pio_out_pulse #(
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int unsigned           PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_LEN    = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_PULSE  = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLR    = 3'd5;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  assign wr_en    = chipselect & ~write_n;
  assign out_port = data_q;
  assign readdata = rdata_q;

`ifdef OUTPIO_PULSE_EN
  logic [PULSE_CNT_WIDTH-1:0] len_q, len_d;
  logic [PULSE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]      mask_q, mask_d;
  logic                       busy_q, busy_d;
  logic                       expire;

  assign expire = busy_q && (cnt_q == PULSE_CNT_WIDTH'(1));

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    mask_d = mask_q;
    busy_d = busy_q;
    // Expiry is applied first so that any write landing on the same edge takes precedence.
    if (expire) begin
      data_d = data_q & ~mask_q;
      mask_d = '0;
      busy_d = 1'b0;
    end
    if (busy_q) begin
      cnt_d = cnt_q - PULSE_CNT_WIDTH'(1);
    end
    if (wr_en) begin
      case (address)
        ADDR_DATA: data_d = writedata;
        ADDR_LEN:  len_d  = writedata[PULSE_CNT_WIDTH-1:0];
        ADDR_PULSE: begin
          if (len_q != '0) begin
            data_d = data_d | writedata;
            mask_d = mask_d | writedata;
            cnt_d  = len_q;
            busy_d = 1'b1;
          end
        end
        ADDR_SET:  data_d = data_d | writedata;
        ADDR_CLR:  data_d = data_d & ~writedata;
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:   rdata_d = data_q;
      ADDR_LEN:    rdata_d[PULSE_CNT_WIDTH-1:0] = len_q;
      ADDR_STATUS: rdata_d[0] = busy_q;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q  <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      busy_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      busy_q <= busy_d;
    end
  end
`else
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA: data_d = writedata;
        ADDR_SET:  data_d = data_q | writedata;
        ADDR_CLR:  data_d = data_q & ~writedata;
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (address == ADDR_DATA) begin
      rdata_d = data_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_niossoc_pio_out_pulse.sv
// Directed self-checking bench for niossoc_pio_out_pulse (RESET_VALUE = 0xA5).
// Pulse-engine vectors run only when OUTPIO_PULSE_EN is defined; otherwise the disabled register slots are checked.
`timescale 1ns/1ps
module tb_niossoc_pio_out_pulse;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic [DW-1:0] out_port;

  int passCount;
  int checkCount;
  logic [2:0] parkAddr;

  niossoc_pio_out_pulse #(
    .DATA_WIDTH(32),
    .RESET_VALUE(32'h0000_00A5),
    .PULSE_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single funnel for every comparison so the pass/total counts stay honest.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
  endtask

  // One-cycle write launched at a falling edge; returns on the next falling edge with the write committed.
  task automatic applyStimulus(input logic [2:0] addr, input logic [DW-1:0] data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = parkAddr;
    writedata  = '0;
  endtask

  task automatic readReg(input logic [2:0] addr, output logic [DW-1:0] value);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = addr;
    @(negedge clk);
    value      = readdata;
    chipselect = 1'b0;
    address    = parkAddr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rv;
    logic [DW-1:0] expSeq [7];
    logic [DW-1:0] expRet [5];
    int changes;

    passCount  = 0;
    checkCount = 0;
    parkAddr   = 3'd0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;

    // Reset state and first read.
    idle(2);
    checkOutput("reset_out_port", out_port, 32'h0000_00A5);
    checkOutput("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    readReg(3'd0, rv);
    checkOutput("read_data_after_reset", rv, 32'h0000_00A5);

    // DATA / OUTSET / OUTCLEAR on consecutive cycles.
    applyStimulus(3'd0, 32'h0000_FF00);
    checkOutput("data_write", out_port, 32'h0000_FF00);
    applyStimulus(3'd4, 32'h0000_000F);
    checkOutput("outset", out_port, 32'h0000_FF0F);
    applyStimulus(3'd5, 32'h0000_0F00);
    checkOutput("outclear", out_port, 32'h0000_F00F);
    readReg(3'd4, rv);
    checkOutput("read_outset_zero", rv, 32'h0);
    readReg(3'd0, rv);
    checkOutput("read_data_f00f", rv, 32'h0000_F00F);
    readReg(3'd7, rv);
    checkOutput("read_addr7_zero", rv, 32'h0);
    applyStimulus(3'd6, 32'hFFFF_FFFF);
    checkOutput("addr6_write_ignored", out_port, 32'h0000_F00F);

`ifdef OUTPIO_PULSE_EN
    // PULSE_LEN readback keeps only the low 16 bits.
    applyStimulus(3'd1, 32'hABCD_0003);
    readReg(3'd1, rv);
    checkOutput("pulse_len_readback", rv, 32'h0000_0003);

    // Single 3-cycle pulse on bit0 with STATUS observed.
    applyStimulus(3'd0, 32'h0);
    parkAddr = 3'd2;
    applyStimulus(3'd3, 32'h1);
    checkOutput("pulse3_c1", out_port, 32'h1);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("pulse3_c%0d", c), out_port, (c <= 3) ? 32'h1 : 32'h0);
      if (c == 2) checkOutput("status_busy", readdata, 32'h1);
      if (c == 5) checkOutput("status_idle", readdata, 32'h0);
    end
    parkAddr = 3'd0;

    // Retrigger two cycles into a 4-cycle pulse.
    expSeq = '{32'h1, 32'h1, 32'h3, 32'h3, 32'h3, 32'h3, 32'h0};
    applyStimulus(3'd1, 32'h4);
    applyStimulus(3'd3, 32'h1);
    checkOutput("retrig_c1", out_port, expSeq[0]);
    @(negedge clk);
    checkOutput("retrig_c2", out_port, expSeq[1]);
    applyStimulus(3'd3, 32'h2);
    checkOutput("retrig_c3", out_port, expSeq[2]);
    for (int c = 3; c < 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("retrig_c%0d", c + 1), out_port, expSeq[c]);
    end

    // OUTSET landing on the expiry edge wins over the clear.
    applyStimulus(3'd1, 32'h2);
    applyStimulus(3'd3, 32'h3);
    checkOutput("exp_set_c1", out_port, 32'h3);
    @(negedge clk);
    checkOutput("exp_set_c2", out_port, 32'h3);
    applyStimulus(3'd4, 32'h1);
    checkOutput("exp_set_after", out_port, 32'h1);
    readReg(3'd2, rv);
    checkOutput("exp_set_status", rv, 32'h0);

    // PULSE with PULSE_LEN = 0 is ignored.
    applyStimulus(3'd1, 32'h0);
    applyStimulus(3'd3, 32'h8);
    checkOutput("len0_out", out_port, 32'h1);
    readReg(3'd2, rv);
    checkOutput("len0_status", rv, 32'h0);

    // PULSE write on the expiry edge: old bits cleared, new bits set, still busy.
    expRet = '{32'h1, 32'h1, 32'h2, 32'h2, 32'h0};
    applyStimulus(3'd0, 32'h0);
    applyStimulus(3'd1, 32'h2);
    applyStimulus(3'd3, 32'h1);
    checkOutput("exp_pulse_c1", out_port, expRet[0]);
    @(negedge clk);
    checkOutput("exp_pulse_c2", out_port, expRet[1]);
    applyStimulus(3'd3, 32'h2);
    checkOutput("exp_pulse_c3", out_port, expRet[2]);
    @(negedge clk);
    checkOutput("exp_pulse_c4", out_port, expRet[3]);
    @(negedge clk);
    checkOutput("exp_pulse_c5", out_port, expRet[4]);

    // Reset mid-pulse aborts it; no late clear afterwards.
    applyStimulus(3'd1, 32'd10);
    applyStimulus(3'd3, 32'h0000_00F0);
    checkOutput("midrst_pulse_on", out_port, 32'h0000_00F0);
    idle(2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midrst_out", out_port, 32'h0000_00A5);
    readReg(3'd2, rv);
    checkOutput("midrst_status", rv, 32'h0);
    changes = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_port !== 32'h0000_00A5) changes++;
    end
    checkOutput("midrst_no_late_clear", 32'(changes), 32'h0);
`else
    // Pulse-engine slots read zero and ignore writes.
    applyStimulus(3'd1, 32'h0000_0005);
    readReg(3'd1, rv);
    checkOutput("len_slot_zero", rv, 32'h0);
    applyStimulus(3'd3, 32'hFFFF_0000);
    checkOutput("pulse_slot_ignored", out_port, 32'h0000_F00F);
    readReg(3'd2, rv);
    checkOutput("status_slot_zero", rv, 32'h0);
    readReg(3'd3, rv);
    checkOutput("pulse_slot_read_zero", rv, 32'h0);
    idle(5);
    checkOutput("no_auto_clear", out_port, 32'h0000_F00F);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("rereset_out", out_port, 32'h0000_00A5);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
